// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
//   Keypad-side controller for the calculator arithmetic unit. Consumes one
//   key event at a time, builds decimal operands in an entry register and
//   drives the arithmetic unit's register-load strobes, opcode and clear
//   pulse. Presents either the operand being typed or the returned result.
//
// Ports
//   Clock        : single clock, rising edge
//   Reset_n      : asynchronous active-low reset
//   key_valid    : key event present
//   key_code     : 0-9 digit, 10 equals, 11 clear, 16-23 operator (op=[2:0])
//   key_ready    : sequencer accepts a key this cycle
//   au_in        : data bus to the arithmetic unit
//   au_load_a/b/r: single-cycle load strobes
//   au_op        : opcode (always the latched operator)
//   au_clear     : one-cycle clear pulse to the arithmetic unit
//   au_result    : arithmetic unit result
//   disp_value   : entry while typing, au_result while showing a result
//   result_valid : high while disp_value holds a computed result
// ---------------------------------------------------------------------------
module calc_sequencer #(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         key_valid,
  input  logic [4:0]   key_code,
  output logic         key_ready,
  output logic [N-1:0] au_in,
  output logic         au_load_a,
  output logic         au_load_b,
  output logic         au_load_r,
  output logic [2:0]   au_op,
  output logic         au_clear,
  input  logic [N-1:0] au_result,
  output logic [N-1:0] disp_value,
  output logic         result_valid
);

  typedef enum logic [2:0] {
    S_INIT,
    S_ENTER_A,
    S_ENTER_B,
    S_LOAD_B,
    S_EXEC,
    S_REPEAT_A,
    S_SHOW
  } state_t;

  state_t       r_state;
  logic [N-1:0] r_entry;
  logic [2:0]   r_op;
  logic [N-1:0] r_au_in;
  logic         r_load_a;
  logic         r_load_b;
  logic         r_load_r;
  logic         r_clear;
  logic         r_key_ready;
  logic         r_result_valid;

  logic         w_accept;
  logic         w_is_digit;
  logic         w_is_eq;
  logic         w_is_clr;
  logic         w_is_op;
  logic [N-1:0] w_digit;
  logic [N-1:0] w_entry_acc;

  assign w_accept   = key_valid && r_key_ready;
  assign w_is_digit = (key_code < 5'd10);
  assign w_is_eq    = (key_code == 5'd10);
  assign w_is_clr   = (key_code == 5'd11);
  assign w_is_op    = (key_code[4:3] == 2'b10);
  assign w_digit    = N'(key_code[3:0]);
  // Decimal shift-in; the product silently wraps modulo 2^N.
  assign w_entry_acc = r_entry * N'(10) + w_digit;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state        <= S_INIT;
      r_entry        <= '0;
      r_op           <= '0;
      r_au_in        <= '0;
      r_load_a       <= 1'b0;
      r_load_b       <= 1'b0;
      r_load_r       <= 1'b0;
      r_clear        <= 1'b0;
      r_key_ready    <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared unless re-asserted below.
      r_load_a <= 1'b0;
      r_load_b <= 1'b0;
      r_load_r <= 1'b0;
      r_clear  <= 1'b0;

      case (r_state)
        S_INIT: begin
          // key_ready stays low for the clear cycle; the ENTER_A branch
          // raises it one edge later.
          r_clear        <= 1'b1;
          r_entry        <= '0;
          r_key_ready    <= 1'b0;
          r_result_valid <= 1'b0;
          r_state        <= S_ENTER_A;
        end

        S_LOAD_B, S_REPEAT_A: begin
          r_load_r <= 1'b1;
          r_state  <= S_EXEC;
        end

        S_EXEC: begin
          r_state        <= S_SHOW;
          r_result_valid <= 1'b1;
          r_key_ready    <= 1'b1;
        end

        default: begin
          // ENTER_A, ENTER_B and SHOW all accept keys.
          r_key_ready <= 1'b1;
          if (w_accept) begin
            if (w_is_clr) begin
              r_clear        <= 1'b1;
              r_entry        <= '0;
              r_result_valid <= 1'b0;
              r_state        <= S_ENTER_A;
            end else if (w_is_digit) begin
              if (r_state == S_SHOW) begin
                r_entry        <= w_digit;
                r_result_valid <= 1'b0;
                r_state        <= S_ENTER_A;
              end else begin
                r_entry <= w_entry_acc;
              end
            end else if (w_is_op) begin
              r_op <= key_code[2:0];
              if (r_state == S_ENTER_A) begin
                r_au_in  <= r_entry;
                r_load_a <= 1'b1;
                r_entry  <= '0;
                r_state  <= S_ENTER_B;
              end else if (r_state == S_SHOW) begin
                // Chaining: the shown result becomes operand A.
                r_au_in        <= au_result;
                r_load_a       <= 1'b1;
                r_entry        <= '0;
                r_result_valid <= 1'b0;
                r_state        <= S_ENTER_B;
              end
            end else if (w_is_eq) begin
              if (r_state == S_ENTER_B) begin
                r_au_in     <= r_entry;
                r_load_b    <= 1'b1;
                r_key_ready <= 1'b0;
                r_state     <= S_LOAD_B;
              end else if (r_state == S_SHOW) begin
                // Repeat: reload A with the result, keep B and the opcode.
                r_au_in        <= au_result;
                r_load_a       <= 1'b1;
                r_key_ready    <= 1'b0;
                r_result_valid <= 1'b0;
                r_state        <= S_REPEAT_A;
              end
            end
          end
        end
      endcase
    end
  end

  assign key_ready    = r_key_ready;
  assign au_in        = r_au_in;
  assign au_load_a    = r_load_a;
  assign au_load_b    = r_load_b;
  assign au_load_r    = r_load_r;
  assign au_op        = r_op;
  assign au_clear     = r_clear;
  assign result_valid = r_result_valid;
  // The arithmetic unit registers R on the same edge that enters SHOW, so the
  // result is passed straight through rather than re-registered.
  assign disp_value   = r_result_valid ? au_result : r_entry;

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;
  localparam int N = 8;

  logic         Clock = 1'b0;
  logic         Reset_n;
  logic         key_valid;
  logic [4:0]   key_code;
  logic         key_ready;
  logic [N-1:0] au_in;
  logic         au_load_a, au_load_b, au_load_r;
  logic [2:0]   au_op;
  logic         au_clear;
  logic [N-1:0] au_result;
  logic [N-1:0] disp_value;
  logic         result_valid;

  calc_sequencer #(.N(N)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .au_in(au_in), .au_load_a(au_load_a), .au_load_b(au_load_b),
    .au_load_r(au_load_r), .au_op(au_op), .au_clear(au_clear), .au_result(au_result),
    .disp_value(disp_value), .result_valid(result_valid)
  );

  always #5 Clock = ~Clock;

  // Arithmetic operation used by both the stub unit and the reference model.
  function automatic int alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a * b;
      6: r = a;
      default: r = b;
    endcase
    return r & 255;
  endfunction

  // Stub arithmetic unit.
  int au_a, au_b, au_r;
  always @(posedge Clock) begin
    if (au_clear) begin
      au_a <= 0; au_b <= 0; au_r <= 0;
    end else begin
      if (au_load_a) au_a <= int'(au_in);
      if (au_load_b) au_b <= int'(au_in);
      if (au_load_r) au_r <= alu(int'(au_op), au_a, au_b);
    end
  end
  assign au_result = au_r[N-1:0];

  // Scoreboard
  localparam int K_CLR = 0, K_LA = 1, K_LB = 2, K_LR = 3;
  typedef struct { int kind; int val; int op; } ev_t;
  ev_t exp_q[$];
  int  res_q[$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: calculator semantics at the key level.
  int m_entry, m_op, m_mode, m_a, m_b, m_r;   // m_mode: 0 typing A, 1 typing B, 2 showing

  function automatic void push_ev(input int kind, input int val, input int op);
    ev_t e;
    e.kind = kind; e.val = val; e.op = op;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_entry = 0; m_op = 0; m_mode = 0; m_a = 0; m_b = 0; m_r = 0;
  endfunction

  function automatic void model_key(input int code, output bit computes);
    computes = 0;
    if (code == 11) begin
      push_ev(K_CLR, 0, 0);
      m_entry = 0; m_mode = 0; m_a = 0; m_b = 0; m_r = 0;
    end else if (code < 10) begin
      if (m_mode == 2) begin m_entry = code; m_mode = 0; end
      else m_entry = (m_entry * 10 + code) % 256;
    end else if (code >= 16 && code <= 23) begin
      if (m_mode == 0) begin
        m_op = code - 16; push_ev(K_LA, m_entry, m_op);
        m_a = m_entry; m_entry = 0; m_mode = 1;
      end else if (m_mode == 1) begin
        m_op = code - 16;
      end else begin
        m_op = code - 16; push_ev(K_LA, m_r, m_op);
        m_a = m_r; m_entry = 0; m_mode = 1;
      end
    end else if (code == 10) begin
      if (m_mode == 1) begin
        push_ev(K_LB, m_entry, m_op); push_ev(K_LR, 0, m_op);
        m_b = m_entry; m_r = alu(m_op, m_a, m_b); res_q.push_back(m_r);
        m_mode = 2; computes = 1;
      end else if (m_mode == 2) begin
        push_ev(K_LA, m_r, m_op); push_ev(K_LR, 0, m_op);
        m_a = m_r; m_r = alu(m_op, m_a, m_b); res_q.push_back(m_r);
        computes = 1;
      end
    end
  endfunction

  // Monitor: pops expectations whenever the DUT issues a strobe or a result.
  initial begin
    bit prev_rv = 0;
    forever begin
      @(negedge Clock);
      if (Reset_n === 1'b1) begin
        int ns, k;
        ev_t e;
        ns = int'(au_clear) + int'(au_load_a) + int'(au_load_b) + int'(au_load_r);
        if (ns != 0) begin
          chk("one_strobe", int'(ns <= 1), 1);
          k = au_clear ? K_CLR : au_load_a ? K_LA : au_load_b ? K_LB : K_LR;
          if (exp_q.size() == 0) chk("unexpected_strobe_kind", k, -1);
          else begin
            e = exp_q.pop_front();
            chk("strobe_kind", k, e.kind);
            if (e.kind == K_LA || e.kind == K_LB) chk("au_in", int'(au_in), e.val);
            if (e.kind == K_LA || e.kind == K_LR) chk("au_op", int'(au_op), e.op);
            $display("strobe kind=%0d au_in=%0d au_op=%0d", k, au_in, au_op);
          end
        end
        if (result_valid && !prev_rv) begin
          if (res_q.size() == 0) chk("unexpected_result", int'(disp_value), -1);
          else chk("result", int'(disp_value), res_q.pop_front());
        end
        prev_rv = result_valid;
      end else prev_rv = 0;
    end
  end

  // Present one key, hold it until consumed, then check immediate effects.
  task automatic do_key(input int code);
    int  n = 0;
    bit  ok = 0;
    bit  computes;
    @(negedge Clock);
    key_valid = 1'b1;
    key_code  = 5'(code);
    while (!ok && n < 20) begin
      if (key_ready) begin @(posedge Clock); ok = 1; end
      else begin @(negedge Clock); n++; end
    end
    if (!ok) begin
      chk("key_ready_timeout", 0, 1);
      key_valid = 1'b0;
      return;
    end
    model_key(code, computes);
    #1 key_valid = 1'b0;
    $display("key %0d consumed disp=%0d", code, disp_value);
    if (computes) begin
      chk("rv_k1", int'(result_valid), 0);
      chk("ready_k1", int'(key_ready), 0);
      @(posedge Clock); #1;
      chk("rv_k2", int'(result_valid), 0);
      @(posedge Clock); #1;
      chk("rv_k3", int'(result_valid), 1);
      chk("ready_k3", int'(key_ready), 1);
    end else begin
      chk("ready_hold", int'(key_ready), 1);
      if (code < 10) begin
        chk("disp_entry", int'(disp_value), m_entry);
        chk("rv_typing", int'(result_valid), 0);
      end
    end
  endtask

  initial begin
    Reset_n = 1'b0; key_valid = 1'b0; key_code = '0;
    model_reset();
    repeat (3) @(negedge Clock);
    chk("rst_clear", int'(au_clear), 0);
    chk("rst_ready", int'(key_ready), 0);
    chk("rst_disp", int'(disp_value), 0);
    chk("rst_rv", int'(result_valid), 0);
    chk("rst_au_in", int'(au_in), 0);

    push_ev(K_CLR, 0, 0);
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    chk("init_clear", int'(au_clear), 1);
    chk("init_ready", int'(key_ready), 0);
    @(posedge Clock); #1;
    chk("init_clear_once", int'(au_clear), 0);
    chk("ready_after_init", int'(key_ready), 1);
    chk("disp_after_init", int'(disp_value), 0);

    // 12 + 3
    do_key(1); do_key(2); do_key(16); do_key(3); do_key(10);
    chk("plan_sum", int'(disp_value), 15);
    // chain: 15 - 2
    do_key(17); do_key(2); do_key(10);
    chk("plan_chain", int'(disp_value), 13);
    // repeat equals: 13 - 2
    do_key(10);
    chk("plan_repeat", int'(disp_value), 11);
    // clear then wrapping entry
    do_key(11);
    chk("clear_rv", int'(result_valid), 0);
    do_key(9); chk("wrap_9", int'(disp_value), 9);
    do_key(9); chk("wrap_99", int'(disp_value), 99);
    do_key(9); chk("wrap_999", int'(disp_value), 231);

    // Reset asserted while the result load is in flight.
    do_key(16); do_key(4);
    @(negedge Clock);
    key_valid = 1'b1; key_code = 5'd10;
    if (key_ready) begin
      bit c;
      @(posedge Clock);
      model_key(10, c);
      #1 key_valid = 1'b0;
      chk("abort_load_b", int'(au_load_b), 1);
      @(posedge Clock); #1;
      chk("abort_load_r_pre", int'(au_load_r), 1);
      Reset_n = 1'b0;
      #1;
      chk("abort_load_r", int'(au_load_r), 0);
      chk("abort_ready", int'(key_ready), 0);
      chk("abort_disp", int'(disp_value), 0);
      chk("abort_au_op", int'(au_op), 0);
      chk("abort_au_in", int'(au_in), 0);
    end else begin
      key_valid = 1'b0;
      chk("abort_setup_ready", int'(key_ready), 1);
      Reset_n = 1'b0;
    end
    exp_q.delete(); res_q.delete();
    repeat (3) begin
      @(negedge Clock);
      chk("rst_quiet", int'(au_clear) + int'(au_load_a) + int'(au_load_b) + int'(au_load_r), 0);
    end
    model_reset();
    push_ev(K_CLR, 0, 0);
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    chk("reinit_clear", int'(au_clear), 1);
    @(posedge Clock); #1;
    chk("reinit_ready", int'(key_ready), 1);

    // Randomized key stream.
    for (int i = 0; i < 400; i++) begin
      int r, code;
      r = $urandom_range(0, 99);
      if (r < 50)      code = $urandom_range(0, 9);
      else if (r < 68) code = $urandom_range(16, 23);
      else if (r < 88) code = 10;
      else if (r < 93) code = 11;
      else if (r < 97) code = $urandom_range(12, 15);
      else             code = $urandom_range(24, 31);
      do_key(code);
      repeat ($urandom_range(0, 2)) @(negedge Clock);
    end

    begin
      int n = 0;
      while ((exp_q.size() != 0 || res_q.size() != 0) && n < 50) begin
        @(negedge Clock); n++;
      end
      chk("drain_events", exp_q.size(), 0);
      chk("drain_results", res_q.size(), 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
